ibuf_mac_array: RTL and testbench

Input-staging buffer plus 4x4 weight-stationary systolic MAC array, forming the matrix-multiply datapath Y = X·W for 4x4 8-bit matrices. X rows are loaded into an internal buffer and W rows into the array's PE registers. A start pulse then streams X in diagonal (skewed) order through the array. Column results emerge skewed at the bottom as 16-bit sums with per-column valid flags.

---
 rtl/ibuf_mac_pkg.sv | 34 +++
 rtl/ibuf_mac_array_if.sv | 27 ++
 rtl/ibuf_mac_pe.sv | 50 +++++
 rtl/ibuf_mac_array.sv | 150 +++++++++++++++
 tb/tb_ibuf_mac_array.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ibuf_mac_pkg.sv
// Shared constants, FSM state type, skew-step record and the PE multiply
// helper for the ibuf_mac_array datapath.
// Build option: SIGNED_MAC_EN selects signed int8 operands (default unsigned).
package ibuf_mac_pkg;

  localparam int DIM          = 4;
  localparam int DATA_W       = 8;
  localparam int ACC_W        = 16;
  localparam int STREAM_STEPS = 7;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  // One step of the diagonal feed: per-lane valid plus the lane bytes.
  typedef struct packed {
    logic [DIM-1:0]        vld;
    logic [DIM*DATA_W-1:0] data;
  } step_t;

  // 8x8 product widened to the accumulator width; wraps mod 2^ACC_W.
  function automatic logic [ACC_W-1:0] mac_mult(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] w);
`ifdef SIGNED_MAC_EN
    logic signed [ACC_W-1:0] p;
    p = ACC_W'($signed(a)) * ACC_W'($signed(w));
    return p;
`else
    return ACC_W'(a) * ACC_W'(w);
`endif
  endfunction

endpackage

// File: rtl/ibuf_mac_array_if.sv
// Load / start / result bus of ibuf_mac_array. The master side drives
// operands and control, the slave side (the array) returns the stream and sums.
interface ibuf_mac_array_if;
  logic        LOAD_EN;
  logic [1:0]  IDST;
  logic [31:0] IWord;
  logic        START_CALC;
  logic [3:0]  ODST_i;
  logic [3:0]  ODST_o;
  logic        W_LOAD;
  logic [1:0]  WROW;
  logic [31:0] WDATA;
  logic [31:0] IROW_o;
  logic [3:0]  ICOL_VALID;
  logic [63:0] ODATA;
  logic [3:0]  OVALID;

  modport master (
    output LOAD_EN, IDST, IWord, START_CALC, ODST_i, W_LOAD, WROW, WDATA,
    input  ODST_o, IROW_o, ICOL_VALID, ODATA, OVALID
  );

  modport slave (
    input  LOAD_EN, IDST, IWord, START_CALC, ODST_i, W_LOAD, WROW, WDATA,
    output ODST_o, IROW_o, ICOL_VALID, ODATA, OVALID
  );
endinterface

// File: rtl/ibuf_mac_pe.sv
// Weight-stationary processing element: holds one weight, forwards the
// activation to the right and the partial sum downward, one cycle per hop.
module mac_pe
  import ibuf_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic              v_in,
  input  logic [ACC_W-1:0]  p_in,
  output logic [DATA_W-1:0] a_out,
  output logic              v_out,
  output logic [ACC_W-1:0]  p_out
);

  logic [DATA_W-1:0] w_q, w_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              v_q, v_d;
  logic [ACC_W-1:0]  p_q, p_d;

  // Next state: weight load, activation forward, multiply-accumulate.
  always_comb begin
    w_d = w_we ? w_in : w_q;
    a_d = a_in;
    v_d = v_in;
    p_d = p_in + mac_mult(a_in, w_q);
  end

  // PE registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      a_q <= '0;
      v_q <= 1'b0;
      p_q <= '0;
    end else begin
      w_q <= w_d;
      a_q <= a_d;
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign a_out = a_q;
  assign v_out = v_q;
  assign p_out = p_q;

endmodule

// File: rtl/ibuf_mac_array.sv
// X staging buffer, stream FSM, diagonal skew generator, destination tag
// register and the 4x4 grid of mac_pe instances computing Y = X*W.
// Build option: SIGNED_MAC_EN (signed operands, see ibuf_mac_pkg).
module ibuf_mac_array
  import ibuf_mac_pkg::*;
(
  input logic              CLK,
  input logic              RSTN,
  ibuf_mac_array_if.slave  bus
);

  localparam logic [2:0] T_LAST = 3'(STREAM_STEPS - 1);

  logic [DIM-1:0][DIM*DATA_W-1:0] x_q, x_d;
  state_t                         state_q, state_d;
  logic [2:0]                     t_q, t_d;
  logic [DIM*DATA_W-1:0]          irow_q, irow_d;
  logic [DIM-1:0]                 icol_q, icol_d;
  logic [3:0]                     odst_q, odst_d;
  step_t                          step_nx;

  // Lane r carries X[t-r][r] while 0 <= t-r < DIM, otherwise zero.
  function automatic step_t skew_step(input logic [2:0] t,
                                      input logic [DIM-1:0][DIM*DATA_W-1:0] x);
    step_t s;
    int    m;
    s = '0;
    for (int r = 0; r < DIM; r++) begin
      m = int'(t) - r;
      if (m >= 0 && m < DIM) begin
        s.vld[r]                    = 1'b1;
        s.data[r*DATA_W +: DATA_W]  = x[m[1:0]][r*DATA_W +: DATA_W];
      end
    end
    return s;
  endfunction

  // Buffer writes, FSM sequencing and the next registered stream step.
  // An accepted start reads x_d so a same-edge row write is already visible.
  always_comb begin
    x_d     = x_q;
    state_d = state_q;
    t_d     = t_q;
    odst_d  = odst_q;
    step_nx = '0;
    if (state_q == ST_IDLE) begin
      if (bus.LOAD_EN) x_d[bus.IDST] = bus.IWord;
      if (bus.START_CALC) begin
        state_d = ST_STREAM;
        t_d     = 3'd0;
        odst_d  = bus.ODST_i;
        step_nx = skew_step(3'd0, x_d);
      end
    end else begin
      if (t_q == T_LAST) begin
        state_d = ST_IDLE;
        t_d     = 3'd0;
      end else begin
        t_d     = t_q + 3'd1;
        step_nx = skew_step(t_q + 3'd1, x_q);
      end
    end
    irow_d = step_nx.data;
    icol_d = step_nx.vld;
  end

  // Control, buffer and stream registers, all cleared by reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      x_q     <= '0;
      state_q <= ST_IDLE;
      t_q     <= 3'd0;
      irow_q  <= '0;
      icol_q  <= '0;
      odst_q  <= '0;
    end else begin
      x_q     <= x_d;
      state_q <= state_d;
      t_q     <= t_d;
      irow_q  <= irow_d;
      icol_q  <= icol_d;
      odst_q  <= odst_d;
    end
  end

  logic [DATA_W-1:0] a_w [DIM][DIM];
  logic              v_w [DIM][DIM];
  logic [ACC_W-1:0]  p_w [DIM][DIM];

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [DATA_W-1:0] a_in;
      logic              v_in;
      logic [ACC_W-1:0]  p_in;

      if (c == 0) begin : g_feed
        assign a_in = irow_q[r*DATA_W +: DATA_W];
        assign v_in = icol_q[r];
      end else begin : g_left
        assign a_in = a_w[r][c-1];
        assign v_in = v_w[r][c-1];
      end

      if (r == 0) begin : g_top
        assign p_in = '0;
      end else begin : g_up
        assign p_in = p_w[r-1][c];
      end

      mac_pe u_pe (
        .clk   (CLK),
        .rst_n (RSTN),
        .w_we  (bus.W_LOAD && (bus.WROW == 2'(r))),
        .w_in  (bus.WDATA[c*DATA_W +: DATA_W]),
        .a_in  (a_in),
        .v_in  (v_in),
        .p_in  (p_in),
        .a_out (a_w[r][c]),
        .v_out (v_w[r][c]),
        .p_out (p_w[r][c])
      );
    end
  end

  logic [DIM*ACC_W-1:0] odata_w;
  logic [DIM-1:0]       ovld_w;
  logic                 edge_unused;

  // Bottom row drives the results; right-edge forwards have no consumer.
  always_comb begin
    odata_w     = '0;
    ovld_w      = '0;
    edge_unused = 1'b0;
    for (int c = 0; c < DIM; c++) begin
      odata_w[c*ACC_W +: ACC_W] = p_w[DIM-1][c];
      ovld_w[c]                 = v_w[DIM-1][c];
    end
    for (int r = 0; r < DIM; r++) begin
      edge_unused = edge_unused ^ (^a_w[r][DIM-1]);
      if (r < DIM - 1) edge_unused = edge_unused ^ v_w[r][DIM-1];
    end
  end

  assign bus.IROW_o     = irow_q;
  assign bus.ICOL_VALID = icol_q;
  assign bus.ODST_o     = odst_q;
  assign bus.ODATA      = odata_w;
  assign bus.OVALID     = ovld_w;

endmodule

// File: tb/tb_ibuf_mac_array.sv
// Directed bench for ibuf_mac_array with a result scoreboard: expected sums
// and their arrival cycles are queued at start and matched on OVALID.
module tb_ibuf_mac_array;
  import ibuf_mac_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ibuf_mac_array_if bif ();

  ibuf_mac_array dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bif)
  );

`ifdef SIGNED_MAC_EN
  localparam logic [15:0] FF_EXP = 16'h0004;
`else
  localparam logic [15:0] FF_EXP = 16'hF804;
`endif

  typedef struct {
    int          col;
    logic [15:0] val;
    int          cy;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  xm [4][4];
  logic [7:0]  wm [4][4];
  logic [3:0]  icol_exp [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and match any column results.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (bif.OVALID[c]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].col == c) idx = i;
        chk($sformatf("ovalid_expected_c%0d", c), 64'(idx >= 0), 64'(1));
        if (idx >= 0) begin
          chk($sformatf("ydata_c%0d", c), 64'(bif.ODATA[c*16 +: 16]), 64'(sb[idx].val));
          chk($sformatf("ytime_c%0d", c), 64'(cyc), 64'(sb[idx].cy));
          sb.delete(idx);
        end
      end
    end
  endtask

  function automatic logic [31:0] row_word(input logic [7:0] m3, m2, m1, m0);
    return {m3, m2, m1, m0};
  endfunction

  function automatic logic [31:0] irow_model(input int k);
    logic [31:0] w;
    w = '0;
    for (int r = 0; r < 4; r++)
      if (k >= r && k <= r + 3) w[r*8 +: 8] = xm[k-r][r];
    return w;
  endfunction

  function automatic logic [15:0] ymodel(input int m, input int c);
    int acc;
    acc = 0;
    for (int r = 0; r < 4; r++) begin
`ifdef SIGNED_MAC_EN
      acc += int'($signed(xm[m][r])) * int'($signed(wm[r][c]));
`else
      acc += int'(xm[m][r]) * int'(wm[r][c]);
`endif
    end
    return acc[15:0];
  endfunction

  task automatic load_w();
    for (int r = 0; r < 4; r++) begin
      bif.W_LOAD = 1'b1;
      bif.WROW   = 2'(r);
      bif.WDATA  = row_word(wm[r][3], wm[r][2], wm[r][1], wm[r][0]);
      tick();
    end
    bif.W_LOAD = 1'b0;
  endtask

  task automatic load_x(input int nrows);
    for (int m = 0; m < nrows; m++) begin
      bif.LOAD_EN = 1'b1;
      bif.IDST    = 2'(m);
      bif.IWord   = row_word(xm[m][3], xm[m][2], xm[m][1], xm[m][0]);
      tick();
    end
    bif.LOAD_EN = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_odata"}, bif.ODATA, 64'(0));
    chk({tag, "_ovalid"}, 64'(bif.OVALID), 64'(0));
    chk({tag, "_irow"}, 64'(bif.IROW_o), 64'(0));
    chk({tag, "_icol"}, 64'(bif.ICOL_VALID), 64'(0));
    chk({tag, "_odst"}, 64'(bif.ODST_o), 64'(0));
  endtask

  // Pulse start, queue expected results, check the skewed feed per step.
  task automatic run_stream(input logic [3:0] tag, input bit with_load, input bit poke,
                            input bit repulse, input int rst_at,
                            input bit ovr, input logic [15:0] ovr_val);
    int   t0;
    exp_t e;
    t0 = cyc + 1;
    bif.START_CALC = 1'b1;
    bif.ODST_i     = tag;
    if (with_load) begin
      bif.LOAD_EN = 1'b1;
      bif.IDST    = 2'd3;
      bif.IWord   = row_word(xm[3][3], xm[3][2], xm[3][1], xm[3][0]);
    end
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 4; c++) begin
        e.col = c;
        e.val = ovr ? ovr_val : ymodel(m, c);
        e.cy  = t0 + m + c + 4;
        sb.push_back(e);
      end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("icol_t%0d", k), 64'(bif.ICOL_VALID), 64'(icol_exp[k]));
      chk($sformatf("irow_t%0d", k), 64'(bif.IROW_o), 64'(irow_model(k)));
      if (k == 0) begin
        bif.START_CALC = 1'b0;
        bif.LOAD_EN    = 1'b0;
        bif.ODST_i     = ~tag;
        chk("odst_capture", 64'(bif.ODST_o), 64'(tag));
      end
      if (k == 1 && poke) begin
        bif.LOAD_EN = 1'b1;
        bif.IDST    = 2'd0;
        bif.IWord   = 32'hDEADBEEF;
      end
      if (k == 2) begin
        bif.LOAD_EN = 1'b0;
        if (repulse) begin
          bif.START_CALC = 1'b1;
          bif.ODST_i     = tag ^ 4'hF;
        end
      end
      if (k == 3) bif.START_CALC = 1'b0;
      if (k == rst_at) begin
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        repeat (3) tick();
        chk("midrst_hold_ovalid", 64'(bif.OVALID), 64'(0));
        rstn = 1'b1;
        return;
      end
    end
    chk("odst_hold", 64'(bif.ODST_o), 64'(tag));
  endtask

  initial begin
    bif.LOAD_EN    = 1'b0;
    bif.IDST       = '0;
    bif.IWord      = '0;
    bif.START_CALC = 1'b0;
    bif.ODST_i     = '0;
    bif.W_LOAD     = 1'b0;
    bif.WROW       = '0;
    bif.WDATA      = '0;

    // Reset state, then idle with no start.
    repeat (2) tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    repeat (3) tick();
    chk("idle_irow", 64'(bif.IROW_o), 64'(0));
    chk("idle_icol", 64'(bif.ICOL_VALID), 64'(0));
    chk("idle_ovalid", 64'(bif.OVALID), 64'(0));

    // All-ones weights, alternating 1/2 rows: every sum is 6; re-pulse ignored.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wm[r][c] = 8'h01;
        xm[r][c] = (((r + c) % 2) == 0) ? 8'h01 : 8'h02;
      end
    load_w();
    load_x(4);
    run_stream(4'h5, 1'b0, 1'b0, 1'b1, -1, 1'b1, 16'h0006);
    repeat (4) tick();

    // Identity weights: columns replay X; last row written with start,
    // write during stream ignored, then a back-to-back stream.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wm[r][c] = (r == c) ? 8'h01 : 8'h00;
        xm[r][c] = 8'(16 * r + c + 1);
      end
    load_w();
    load_x(3);
    run_stream(4'h9, 1'b1, 1'b1, 1'b0, -1, 1'b0, 16'h0000);
    run_stream(4'h3, 1'b0, 1'b0, 1'b0, -1, 1'b0, 16'h0000);
    repeat (5) tick();

    // All operands 0xFF.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wm[r][c] = 8'hFF;
        xm[r][c] = 8'hFF;
      end
    load_w();
    load_x(4);
    run_stream(4'h6, 1'b0, 1'b0, 1'b0, -1, 1'b1, FF_EXP);
    repeat (5) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    // Reset asserted in the middle of a stream.
    run_stream(4'hC, 1'b0, 1'b0, 1'b0, 5, 1'b0, 16'h0000);
    repeat (4) tick();
    chk("post_rst_odst", 64'(bif.ODST_o), 64'(0));
    chk("post_rst_ovalid", 64'(bif.OVALID), 64'(0));
    chk("post_rst_icol", 64'(bif.ICOL_VALID), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
